// File: rtl/angle_rom_reader.sv
// Angle ROM request sequencer: issues ROM reads from a valid/ready
// stream, tracks read latency and buffers tagged words in a FWFT FIFO.
//
// Ports:
//   clk, rst         single clock, async active-high reset
//   req_*            request stream (addr + tag), credit-based ready
//   rom_*            ROM address/strobe/enables out, read data in
//   rsp_*            response stream (data + tag), FIFO head
//   busy             any request in flight or buffered
module angle_rom_reader #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int ROM_LATENCY = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int TAG_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic                  rom_addr_strobe,
   output logic                  rom_clk_en,
   output logic                  rom_rd_oce,
   input  logic [DATA_WIDTH-1:0] rom_rd_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [TAG_WIDTH-1:0]  rsp_tag,
   output logic                  busy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef logic [CW-1:0] cnt_t;

   logic                   run_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [ROM_LATENCY-1:0] vld_q;
   logic [TAG_WIDTH-1:0]   tag_q [ROM_LATENCY];
   cnt_t                   inflight_q, inflight_d;
   cnt_t                   count_q, count_d;
   logic [PW-1:0]          wr_q, rd_q;
   logic [DATA_WIDTH-1:0]  mem_data [FIFO_DEPTH];
   logic [TAG_WIDTH-1:0]   mem_tag  [FIFO_DEPTH];
   logic [CW:0]            used;
   logic                   accept, retire, pop;

   // Credits come only from registered counts, so a pop frees
   // a slot one cycle later and ready never sees rsp_ready.
   assign used      = {1'b0, inflight_q} + {1'b0, count_q};
   assign req_ready = run_q && (used < (CW+1)'(FIFO_DEPTH));
   assign accept    = req_valid && req_ready;
   assign retire    = vld_q[ROM_LATENCY-1];
   assign rsp_valid = (count_q != '0);
   assign pop       = rsp_valid && rsp_ready;

   assign rom_addr        = accept ? req_addr : addr_q;
   assign rom_addr_strobe = accept;
   assign rom_clk_en      = 1'b1;
   assign rom_rd_oce      = 1'b1;

   // Head is gated so idle/reset outputs read as zero.
   assign rsp_data = rsp_valid ? mem_data[rd_q] : '0;
   assign rsp_tag  = rsp_valid ? mem_tag[rd_q]  : '0;
   assign busy     = (inflight_q != '0) || rsp_valid;

   always_comb begin
      inflight_d = inflight_q;
      count_d    = count_q;
      if (accept && !retire)
         inflight_d = inflight_q + cnt_t'(1);
      else if (retire && !accept)
         inflight_d = inflight_q - cnt_t'(1);
      if (retire && !pop)
         count_d = count_q + cnt_t'(1);
      else if (pop && !retire)
         count_d = count_q - cnt_t'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q      <= 1'b0;
         addr_q     <= '0;
         vld_q      <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         for (int i = 0; i < ROM_LATENCY; i++)
            tag_q[i] <= '0;
      end else begin
         run_q      <= 1'b1;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         if (accept)
            addr_q <= req_addr;
         vld_q[0] <= accept;
         tag_q[0] <= req_tag;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
         if (retire)
            wr_q <= wr_q + PW'(1);
         if (pop)
            rd_q <= rd_q + PW'(1);
      end
   end

   // Storage needs no reset: entries are only visible via count_q.
   always_ff @(posedge clk) begin
      if (retire) begin
         mem_data[wr_q] <= rom_rd_data;
         mem_tag[wr_q]  <= tag_q[ROM_LATENCY-1];
      end
   end

   a_no_overflow : assert property (
      @(posedge clk) disable iff (rst)
      !(retire && (count_q == cnt_t'(FIFO_DEPTH)))
   ) else $error("angle_rom_reader: write into full fifo");

endmodule
